// File: rtl/bsg_dram_channel_requester.sv
// ---------------------------------------------------------------------------
// bsg_dram_channel_requester
//
// Initiator side of one test-DRAM channel. A client hands over one read or
// write command at a time on a valid/ready port. The command is registered
// and presented to the channel's request port, and for writes also to its
// write-data port, until both handshakes complete. Read beats come back from
// the channel with no backpressure. They are parked in a return FIFO and
// handed to the client in request order.
//
// A credit counter ("outstanding") counts reads issued to the channel that
// the client has not yet consumed. New reads are refused once it reaches
// max_outstanding_p. Because the FIFO has that many slots, every legal
// returned beat is guaranteed a slot.
//
// Parameters
//   channel_addr_width_p : channel address width, in data words
//   data_width_p         : data word width
//   max_outstanding_p    : read credit limit and return FIFO depth (>= 1)
//
// Ports
//   clk_i, reset_i          : clock; asynchronous active-high reset
//   cmd_v_i / cmd_ready_o   : client command handshake
//   cmd_write_not_read_i    : 1 = write, 0 = read
//   cmd_addr_i, cmd_data_i  : command address and write data
//   resp_v_o, resp_data_o   : head of the read-return FIFO
//   resp_yumi_i             : client pops the FIFO head
//   dram_v_o, dram_write_not_read_o, dram_ch_addr_o, dram_yumi_i
//                           : channel request port
//   dram_data_v_o, dram_data_o, dram_data_yumi_i
//                           : channel write-data port
//   dram_data_v_i, dram_data_i
//                           : channel read-return port (no backpressure)
//   idle_o                  : no command in progress, no reads outstanding,
//                             FIFO empty
//
// Build option
//   BSG_DRAM_CHANNEL_REQUESTER_ASSERT_EN : when defined, simulation-only
//   protocol checks report misuse with $error. Behaviour is unchanged.
// ---------------------------------------------------------------------------
module bsg_dram_channel_requester #(
    parameter int channel_addr_width_p = 16,
    parameter int data_width_p         = 32,
    parameter int max_outstanding_p    = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic                            cmd_v_i,
    input  logic                            cmd_write_not_read_i,
    input  logic [channel_addr_width_p-1:0] cmd_addr_i,
    input  logic [data_width_p-1:0]         cmd_data_i,
    output logic                            cmd_ready_o,

    output logic                            resp_v_o,
    output logic [data_width_p-1:0]         resp_data_o,
    input  logic                            resp_yumi_i,

    output logic                            dram_v_o,
    output logic                            dram_write_not_read_o,
    output logic [channel_addr_width_p-1:0] dram_ch_addr_o,
    input  logic                            dram_yumi_i,

    output logic                            dram_data_v_o,
    output logic [data_width_p-1:0]         dram_data_o,
    input  logic                            dram_data_yumi_i,

    input  logic                            dram_data_v_i,
    input  logic [data_width_p-1:0]         dram_data_i,

    output logic                            idle_o
);

    localparam int count_width_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_width_lp   = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    localparam logic [count_width_lp-1:0] max_count_lp = count_width_lp'(max_outstanding_p);
    localparam logic [ptr_width_lp-1:0]   last_ptr_lp  = ptr_width_lp'(max_outstanding_p - 1);

    typedef enum logic {
        e_idle,
        e_issue
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                            state_r;
    logic                              write_r;
    logic [channel_addr_width_p-1:0]   addr_r;
    logic [data_width_p-1:0]           data_r;
    // Request and write-data valids. Each one is the inverse of its
    // "done" flag while in ISSUE and drops on its own handshake.
    logic                              dram_v_r;
    logic                              dram_data_v_r;

    logic [count_width_lp-1:0]         outstanding_r;
    logic [count_width_lp-1:0]         fifo_count_r;
    logic [ptr_width_lp-1:0]           wr_ptr_r;
    logic [ptr_width_lp-1:0]           rd_ptr_r;
    logic [data_width_p-1:0]           fifo_mem [max_outstanding_p];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic cmd_accept;
    logic req_fire;
    logic read_issued;
    logic issue_done;
    logic resp_pop;
    logic fifo_full;
    logic beat_push;

    // Hold cmd_ready_o low while reset is asserted. The FSM already sits in
    // IDLE then, so without this gate a write would look acceptable.
    assign cmd_ready_o = ~reset_i
                       & (state_r == e_idle)
                       & (cmd_write_not_read_i | (outstanding_r < max_count_lp));

    assign cmd_accept  = cmd_v_i & cmd_ready_o;
    assign req_fire    = dram_v_r & dram_yumi_i;
    assign read_issued = req_fire & ~write_r;

    // Both handshakes are either already complete or completing this cycle.
    // They may arrive in either order or together.
    assign issue_done  = (state_r == e_issue)
                       & (~dram_v_r      | dram_yumi_i)
                       & (~dram_data_v_r | dram_data_yumi_i);

    // A yumi without a valid response is ignored rather than corrupting state.
    assign resp_pop    = resp_v_o & resp_yumi_i;
    assign fifo_full   = (fifo_count_r == max_count_lp);

    // A beat is taken only if a read is outstanding and a slot is free, or
    // is being freed this cycle. Any other beat is dropped with no state change.
    assign beat_push   = dram_data_v_i
                       & (outstanding_r != '0)
                       & (~fifo_full | resp_pop);

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Command FSM
    // -----------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments only, so all
    // registers sample the pre-edge values of one another.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= e_idle;
            write_r       <= 1'b0;
            addr_r        <= '0;
            data_r        <= '0;
            dram_v_r      <= 1'b0;
            dram_data_v_r <= 1'b0;
        end else begin
            unique case (state_r)
                e_idle: begin
                    if (cmd_accept) begin
                        state_r       <= e_issue;
                        write_r       <= cmd_write_not_read_i;
                        addr_r        <= cmd_addr_i;
                        data_r        <= cmd_data_i;
                        dram_v_r      <= 1'b1;
                        // A read has no data phase, so it starts with data done.
                        dram_data_v_r <= cmd_write_not_read_i;
                    end
                end
                e_issue: begin
                    if (dram_yumi_i)      dram_v_r      <= 1'b0;
                    if (dram_data_yumi_i) dram_data_v_r <= 1'b0;
                    if (issue_done)       state_r       <= e_idle;
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read credit counter: reads issued to the channel and not yet consumed
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            outstanding_r <= '0;
        end else begin
            unique case ({read_issued, resp_pop})
                2'b10:   outstanding_r <= outstanding_r + count_width_lp'(1);
                2'b01:   if (outstanding_r != '0) outstanding_r <= outstanding_r - count_width_lp'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Read-return FIFO (no bypass: a beat is visible the cycle after it lands)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (beat_push) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (resp_pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            unique case ({beat_push, resp_pop})
                2'b10:   fifo_count_r <= fifo_count_r + count_width_lp'(1);
                2'b01:   fifo_count_r <= fifo_count_r - count_width_lp'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // NOTE: the storage array has no reset. Its contents are only observed
    // behind fifo_count_r, which is reset, so clearing it would buy nothing.
    always_ff @(posedge clk_i) begin
        if (beat_push) fifo_mem[wr_ptr_r] <= dram_data_i;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dram_v_o              = dram_v_r;
    assign dram_write_not_read_o = write_r;
    assign dram_ch_addr_o        = addr_r;
    assign dram_data_v_o         = dram_data_v_r;
    assign dram_data_o           = data_r;

    assign resp_v_o              = (fifo_count_r != '0);
    assign resp_data_o           = fifo_mem[rd_ptr_r];

    assign idle_o                = (state_r == e_idle)
                                 & (outstanding_r == '0)
                                 & (fifo_count_r == '0);

    // -----------------------------------------------------------------------
    // Protocol checks (simulation only)
    // -----------------------------------------------------------------------
`ifdef BSG_DRAM_CHANNEL_REQUESTER_ASSERT_EN
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (dram_data_v_i && (outstanding_r == '0))
                $error("[%0t] %m: read beat returned with no read outstanding; beat dropped", $time);
            else if (dram_data_v_i && fifo_full && !resp_pop)
                $error("[%0t] %m: read beat returned into a full FIFO; beat dropped", $time);
            if (resp_yumi_i && !resp_v_o)
                $error("[%0t] %m: resp_yumi_i asserted without resp_v_o", $time);
            if (dram_yumi_i && !dram_v_o)
                $error("[%0t] %m: dram_yumi_i asserted without dram_v_o", $time);
            if (dram_data_yumi_i && !dram_data_v_o)
                $error("[%0t] %m: dram_data_yumi_i asserted without dram_data_v_o", $time);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_dram_channel_requester.sv
module tb_bsg_dram_channel_requester;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;

    logic          cmd_v = 1'b0;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_ready_o;

    logic          resp_v_o;
    logic [DW-1:0] resp_data_o;
    logic          resp_yumi = 1'b0;

    logic          dram_v_o;
    logic          dram_write_not_read_o;
    logic [AW-1:0] dram_ch_addr_o;
    logic          dram_yumi = 1'b0;

    logic          dram_data_v_o;
    logic [DW-1:0] dram_data_o;
    logic          dram_data_yumi = 1'b0;

    logic          dram_data_v = 1'b0;
    logic [DW-1:0] dram_data = '0;

    logic          idle_o;

    always #5 clk = ~clk;

    bsg_dram_channel_requester #(
        .channel_addr_width_p (AW),
        .data_width_p         (DW),
        .max_outstanding_p    (MAX)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .cmd_v_i               (cmd_v),
        .cmd_write_not_read_i  (cmd_wr),
        .cmd_addr_i            (cmd_addr),
        .cmd_data_i            (cmd_data),
        .cmd_ready_o           (cmd_ready_o),
        .resp_v_o              (resp_v_o),
        .resp_data_o           (resp_data_o),
        .resp_yumi_i           (resp_yumi),
        .dram_v_o              (dram_v_o),
        .dram_write_not_read_o (dram_write_not_read_o),
        .dram_ch_addr_o        (dram_ch_addr_o),
        .dram_yumi_i           (dram_yumi),
        .dram_data_v_o         (dram_data_v_o),
        .dram_data_o           (dram_data_o),
        .dram_data_yumi_i      (dram_data_yumi),
        .dram_data_v_i         (dram_data_v),
        .dram_data_i           (dram_data),
        .idle_o                (idle_o)
    );

    // Reference model: response queue, read credits, in-flight reads at the channel.
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model_q[$];
    int            model_out = 0;
    int            chan_pending = 0;
    bit            busy = 1'b0;
    bit            cur_is_read = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/resp_v"}, resp_v_o, model_q.size() != 0);
        if (model_q.size() != 0) check({tag, "/resp_data"}, resp_data_o, model_q[0]);
        check({tag, "/idle"}, idle_o, !busy && model_out == 0 && model_q.size() == 0);
    endtask

    // One clock: update the model from what the bench drives, then check.
    task automatic tick(input string tag);
        bit pop, push_ok, rd_inc;
        pop     = resp_yumi && (model_q.size() != 0);
        rd_inc  = dram_yumi && cur_is_read;
        push_ok = dram_data_v && (model_out != 0) && ((model_q.size() < MAX) || pop);
        @(posedge clk);
        if (pop)     void'(model_q.pop_front());
        if (push_ok) model_q.push_back(dram_data);
        if (rd_inc)  model_out++;
        if (pop && model_out > 0) model_out--;
        #1;
        cmd_v = 1'b0; dram_yumi = 1'b0; dram_data_yumi = 1'b0;
        dram_data_v = 1'b0; resp_yumi = 1'b0;
        check_status(tag);
    endtask

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_v = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_data = d;
        #1;
        check("accept/cmd_ready", cmd_ready_o, wr || (model_out < MAX));
        cur_is_read = !wr; cur_addr = a; cur_data = d; busy = 1'b1;
        tick("accept");
    endtask

    task automatic finish_cmd(input int req_delay, input int data_delay);
        int last;
        last = cur_is_read ? req_delay : ((req_delay > data_delay) ? req_delay : data_delay);
        for (int k = 0; k <= last; k++) begin
            check("issue/dram_v", dram_v_o, k <= req_delay);
            check("issue/data_v", dram_data_v_o, !cur_is_read && (k <= data_delay));
            check("issue/type", dram_write_not_read_o, !cur_is_read);
            check("issue/addr", dram_ch_addr_o, cur_addr);
            if (!cur_is_read && k <= data_delay) check("issue/data", dram_data_o, cur_data);
            check("issue/cmd_ready", cmd_ready_o, 1'b0);
            dram_yumi      = (k == req_delay);
            dram_data_yumi = !cur_is_read && (k == data_delay);
            if (k == last) busy = 1'b0;
            tick("issue");
        end
        if (cur_is_read) chan_pending++;
        check("done/cmd_ready", cmd_ready_o, cmd_wr || (model_out < MAX));
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit pop);
        dram_data_v = 1'b1; dram_data = d; resp_yumi = pop;
        tick("beat");
        if (chan_pending > 0) chan_pending--;
    endtask

    task automatic read_dead_test(input string tag);
        send_cmd(1'b0, 8'h10, '0);
        finish_cmd(0, 0);
        repeat (4) tick("wait");
        beat(16'hDEAD, 1'b0);
        check({tag, "/resp_v"}, resp_v_o, 1'b1);
        check({tag, "/resp_data"}, resp_data_o, 16'hDEAD);
        resp_yumi = 1'b1;
        tick("yumi");
        check({tag, "/idle"}, idle_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with a write presented so cmd_ready gating is visible.
        cmd_wr = 1'b1;
        #1;
        check("rst/cmd_ready", cmd_ready_o, 1'b0);
        check("rst/dram_v", dram_v_o, 1'b0);
        check("rst/data_v", dram_data_v_o, 1'b0);
        check("rst/addr", dram_ch_addr_o, '0);
        check("rst/data", dram_data_o, '0);
        check("rst/resp_v", resp_v_o, 1'b0);
        check("rst/idle", idle_o, 1'b1);
        repeat (2) tick("rst");
        reset_i = 1'b0;
        #1;
        check("post_rst/cmd_ready", cmd_ready_o, 1'b1);
        cmd_wr = 1'b0;

        // Single read with a delayed return.
        read_dead_test("read1");

        // Writes: data first, request first, both together.
        send_cmd(1'b1, 8'h20, 16'hBEEF); finish_cmd(3, 0);
        send_cmd(1'b1, 8'h20, 16'hBEEF); finish_cmd(0, 3);
        send_cmd(1'b1, 8'h20, 16'hBEEF); finish_cmd(1, 1);

        // Credit limit: four reads fill all credits.
        for (int i = 0; i < MAX; i++) begin
            send_cmd(1'b0, AW'(8'h40 + i), '0);
            finish_cmd(0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            cmd_v = 1'b1; cmd_wr = 1'b0; cmd_addr = AW'(8'h44 + i);
            #1;
            check("limit/rd_ready", cmd_ready_o, model_out < MAX);
            tick("limit");
            check("limit/no_issue", dram_v_o, 1'b0);
        end
        cmd_wr = 1'b1;
        #1;
        check("limit/wr_ready", cmd_ready_o, 1'b1);
        send_cmd(1'b1, 8'h55, 16'h1234);
        finish_cmd(0, 0);

        // Fill the FIFO, drop a beat into it, then push and pop together.
        for (int i = 0; i < MAX; i++) beat(DW'(16'hA000 + i), 1'b0);
        beat(16'hBAD0, 1'b0);
        beat(16'hA004, 1'b1);
        cmd_wr = 1'b0;
        #1;
        check("limit/reopen", cmd_ready_o, model_out < MAX);
        while (model_q.size() != 0) begin
            resp_yumi = 1'b1;
            tick("drain");
        end

        // Stray beat with nothing outstanding is dropped.
        beat(16'h5555, 1'b0);
        check("stray/resp_v", resp_v_o, 1'b0);

        // Random traffic with a well-behaved channel.
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0: if (model_out < MAX) begin
                       send_cmd(1'b0, AW'($urandom), DW'($urandom));
                       finish_cmd($urandom_range(0, 2), 0);
                   end
                1: begin
                       send_cmd(1'b1, AW'($urandom), DW'($urandom));
                       finish_cmd($urandom_range(0, 3), $urandom_range(0, 3));
                   end
                2: if (chan_pending > 0) beat(DW'($urandom), 1'b0);
                3: if (model_q.size() != 0) begin resp_yumi = 1'b1; tick("rpop"); end
                4: if (chan_pending > 0 && model_q.size() != 0) beat(DW'($urandom), 1'b1);
                default: tick("rnd_idle");
            endcase
        end
        while (chan_pending > 0) beat(DW'($urandom), 1'b0);
        while (model_q.size() != 0) begin resp_yumi = 1'b1; tick("rnd_drain"); end
        check("rnd/idle", idle_o, 1'b1);

        // Reset mid-ISSUE with two reads outstanding.
        send_cmd(1'b0, 8'h31, '0); finish_cmd(0, 0);
        send_cmd(1'b0, 8'h32, '0); finish_cmd(0, 0);
        send_cmd(1'b1, 8'h33, 16'h7777);
        cmd_wr = 1'b1;
        reset_i = 1'b1;
        #1;
        check("midrst/dram_v", dram_v_o, 1'b0);
        check("midrst/data_v", dram_data_v_o, 1'b0);
        check("midrst/addr", dram_ch_addr_o, '0);
        check("midrst/resp_v", resp_v_o, 1'b0);
        check("midrst/idle", idle_o, 1'b1);
        check("midrst/cmd_ready", cmd_ready_o, 1'b0);
        model_q.delete(); model_out = 0; chan_pending = 0; busy = 1'b0;
        tick("midrst");
        reset_i = 1'b0;
        cmd_wr = 1'b0;
        #1;
        read_dead_test("read2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
